readout_capture: RTL and testbench

- Downstream of camera_controller. Consumes its readout strobes (NRE_1, NRE_2, ADC) and the ADC's parallel output word.
- Turns each row conversion into two tagged pixel words (row, col). Buffers them in a small FIFO and presents them on a valid/ready stream to the image-output logic.
- Flags protocol errors and buffer overflow as sticky status bits.

---
 rtl/camera_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/readout_capture.sv | 145 ++++++++++++++
 tb/tb_readout_capture.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera readout path.
// FIFO entries are laid out {row, col, data}, with the tag pair in the upper bits.
package camera_pkg;

    localparam int PIX_ROWS       = 2;
    localparam int PIX_COLS       = 2;
    localparam int DEFAULT_DATA_W = 8;
    localparam int TAG_W          = $clog2(PIX_ROWS) + $clog2(PIX_COLS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        PUSH1
    } cap_state_t;

    typedef struct packed {
        logic row;
        logic col;
    } pix_tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered storage head; pop_data reads as zero while empty.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/readout_capture.sv
// Captures each two-column ADC conversion as tagged pixel words and streams them out.
// Illegal strobe patterns and dropped conversions raise sticky status flags.
module readout_capture
    import camera_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int SAMPLE_DELAY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                NRE_1,
    input  logic                NRE_2,
    input  logic                ADC,
    input  logic [2*DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0]   pixel_data,
    output logic                pixel_row,
    output logic                pixel_col,
    output logic                pixel_valid,
    input  logic                pixel_ready,
    output logic                frame_done,
    output logic                overflow,
    output logic                protocol_err
);

    localparam int ENTRY_W = DATA_W + TAG_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    cap_state_t          state;
    cap_state_t          state_next;
    logic                adc_q;
    logic                rise;
    logic                row_q;
    logic                row_next;
    logic [2:0]          dly_q;
    logic [2:0]          dly_next;
    logic [DATA_W-1:0]   data_hi_q;
    logic                push;
    logic [ENTRY_W-1:0]  push_entry;
    logic [ENTRY_W-1:0]  head_entry;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    fifo_free;
    logic                fifo_full;
    logic                fifo_empty;
    logic                set_overflow;
    logic                set_protocol;
    logic                frame_pulse;

    assign rise      = ADC & ~adc_q;
    assign fifo_free = CNT_W'(FIFO_DEPTH) - fifo_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            adc_q        <= 1'b0;
            row_q        <= 1'b0;
            dly_q        <= '0;
            data_hi_q    <= '0;
            overflow     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_next;
            adc_q        <= ADC;
            row_q        <= row_next;
            dly_q        <= dly_next;
            overflow     <= overflow | set_overflow;
            protocol_err <= protocol_err | set_protocol;
            if (state == SAMPLE) begin
                data_hi_q <= adc_data[2*DATA_W-1:DATA_W];
            end
        end
    end

    // Both columns are committed only when two slots are free, so a frame never holds half a row.
    always_comb begin
        state_next   = state;
        row_next     = row_q;
        dly_next     = dly_q;
        push         = 1'b0;
        push_entry   = '0;
        set_overflow = 1'b0;
        set_protocol = 1'b0;
        frame_pulse  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    if (NRE_1 ^ NRE_2) begin
                        row_next   = ~NRE_2;
                        dly_next   = 3'(SAMPLE_DELAY);
                        state_next = (SAMPLE_DELAY == 0) ? SAMPLE : WAIT;
                    end else begin
                        set_protocol = 1'b1;
                    end
                end
            end
            WAIT: begin
                set_protocol = rise;
                dly_next     = dly_q - 3'd1;
                if (dly_q <= 3'd1) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                set_protocol = rise;
                if (!fifo_full && fifo_free >= CNT_W'(2)) begin
                    push       = 1'b1;
                    push_entry = {pix_tag_t'{row: row_q, col: 1'b0}, adc_data[DATA_W-1:0]};
                    state_next = PUSH1;
                end else begin
                    set_overflow = 1'b1;
                    state_next   = IDLE;
                end
            end
            PUSH1: begin
                set_protocol = rise;
                push         = 1'b1;
                push_entry   = {pix_tag_t'{row: row_q, col: 1'b1}, data_hi_q};
                frame_pulse  = row_q;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign frame_done = frame_pulse & ~rst;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pixel_ready & pixel_valid),
        .pop_data  (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pixel_valid = ~fifo_empty;
    assign {pixel_row, pixel_col, pixel_data} = head_entry;

endmodule

// File: tb/tb_readout_capture.sv
// Directed, table-driven bench for readout_capture with a monitor that records every accepted pixel.
module tb_readout_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        NRE_1 = 1'b1;
    logic        NRE_2 = 1'b1;
    logic        ADC = 1'b0;
    logic [15:0] adc_data = '0;
    logic [7:0]  pixel_data;
    logic        pixel_row;
    logic        pixel_col;
    logic        pixel_valid;
    logic        pixel_ready = 1'b0;
    logic        frame_done;
    logic        overflow;
    logic        protocol_err;

    int          checks = 0;
    int          errors = 0;
    int          fd_count = 0;
    logic [9:0]  out_q[$];

    typedef struct {
        logic        nre1;
        logic        nre2;
        logic [15:0] adc;
        logic [9:0]  exp0;
        logic [9:0]  exp1;
    } vec_t;

    vec_t vecs[16];

    readout_capture dut (
        .clk          (clk),
        .rst          (rst),
        .NRE_1        (NRE_1),
        .NRE_2        (NRE_2),
        .ADC          (ADC),
        .adc_data     (adc_data),
        .pixel_data   (pixel_data),
        .pixel_row    (pixel_row),
        .pixel_col    (pixel_col),
        .pixel_valid  (pixel_valid),
        .pixel_ready  (pixel_ready),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    // Records every handshake as {row, col, data}; pops happen at the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid && pixel_ready) begin
                out_q.push_back({pixel_row, pixel_col, pixel_data});
            end
            if (frame_done) begin
                fd_count++;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
        ADC   = 1'b0;
        rst   = 1'b1;
        step();
        step();
        rst = 1'b0;
        out_q.delete();
        fd_count = 0;
    endtask

    // One full conversion: ADC pulse with the strobes held until the FSM returns to IDLE.
    task automatic apply_stimulus(input logic n1, input logic n2, input logic [15:0] d);
        NRE_1    = n1;
        NRE_2    = n2;
        adc_data = d;
        ADC      = 1'b1;
        step();
        ADC = 1'b0;
        step();
        step();
        step();
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
    endtask

    task automatic wait_entries(input int n, input string name);
        int budget = 200;
        while (out_q.size() < n && budget > 0) begin
            step();
            budget--;
        end
        repeat (4) step();
        check_output({name, "_count"}, out_q.size(), n);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[2*i]   = '{nre1: 1'b0, nre2: 1'b1,
                            adc:  {8'hB3 + 8'(i), 8'hA1 + 8'(i)},
                            exp0: {2'b00, 8'hA1 + 8'(i)},
                            exp1: {2'b01, 8'hB3 + 8'(i)}};
            vecs[2*i+1] = '{nre1: 1'b1, nre2: 1'b0,
                            adc:  {8'h7F - 8'(i), 8'h02 + 8'(i)},
                            exp0: {2'b10, 8'h02 + 8'(i)},
                            exp1: {2'b11, 8'h7F - 8'(i)}};
        end

        step();
        step();
        check_output("rst_valid", pixel_valid, 1'b0);
        check_output("rst_data", pixel_data, 8'h00);
        check_output("rst_tags", {pixel_row, pixel_col}, 2'b00);
        check_output("rst_frame_done", frame_done, 1'b0);
        check_output("rst_overflow", overflow, 1'b0);
        check_output("rst_protocol", protocol_err, 1'b0);

        // Backpressured frame, also pinning down first-write latency.
        do_reset();
        pixel_ready = 1'b0;
        NRE_1 = 1'b0;
        adc_data = 16'hB3A1;
        ADC = 1'b1;
        step();
        ADC = 1'b0;
        check_output("lat_wait_valid", pixel_valid, 1'b0);
        step();
        check_output("lat_sample_valid", pixel_valid, 1'b0);
        step();
        check_output("lat_first_valid", pixel_valid, 1'b1);
        check_output("lat_first_entry", {pixel_row, pixel_col, pixel_data}, 10'h0A1);
        step();
        NRE_1 = 1'b1;
        apply_stimulus(1'b1, 1'b0, 16'h7F02);
        check_output("bp_hold_data", pixel_data, 8'hA1);
        check_output("bp_frame_done", fd_count, 1);
        check_output("bp_no_overflow", overflow, 1'b0);
        apply_stimulus(1'b0, 1'b1, 16'h5566);
        check_output("bp_overflow", overflow, 1'b1);
        check_output("bp_protocol", protocol_err, 1'b0);
        check_output("bp_head_after_ovf", {pixel_row, pixel_col, pixel_data}, 10'h0A1);
        pixel_ready = 1'b1;
        wait_entries(4, "bp_drain");
        check_output("bp_out0", out_q[0], 10'h0A1);
        check_output("bp_out1", out_q[1], 10'h1B3);
        check_output("bp_out2", out_q[2], 10'h202);
        check_output("bp_out3", out_q[3], 10'h37F);
        check_output("bp_empty", pixel_valid, 1'b0);
        check_output("bp_frame_total", fd_count, 1);

        // Eight frames streamed back to back, wrapping the FIFO pointers repeatedly.
        do_reset();
        pixel_ready = 1'b1;
        for (int v = 0; v < 16; v++) begin
            apply_stimulus(vecs[v].nre1, vecs[v].nre2, vecs[v].adc);
        end
        wait_entries(32, "stream");
        for (int v = 0; v < 16; v++) begin
            check_output($sformatf("stream_v%0d_col0", v), out_q[2*v], vecs[v].exp0);
            check_output($sformatf("stream_v%0d_col1", v), out_q[2*v+1], vecs[v].exp1);
        end
        check_output("stream_frames", fd_count, 8);
        check_output("stream_overflow", overflow, 1'b0);
        check_output("stream_protocol", protocol_err, 1'b0);

        // Push and pop in the same PUSH1 cycle with three entries held.
        do_reset();
        pixel_ready = 1'b0;
        apply_stimulus(1'b0, 1'b1, 16'h2211);
        NRE_2 = 1'b0;
        adc_data = 16'h4433;
        ADC = 1'b1;
        step();
        ADC = 1'b0;
        step();
        step();
        pixel_ready = 1'b1;
        step();
        pixel_ready = 1'b0;
        NRE_2 = 1'b1;
        check_output("pp_popped_count", out_q.size(), 1);
        check_output("pp_popped_entry", out_q[0], 10'h011);
        apply_stimulus(1'b0, 1'b1, 16'h6655);
        check_output("pp_overflow", overflow, 1'b1);
        pixel_ready = 1'b1;
        wait_entries(4, "pp_drain");
        check_output("pp_out1", out_q[1], 10'h122);
        check_output("pp_out2", out_q[2], 10'h233);
        check_output("pp_out3", out_q[3], 10'h344);

        // Illegal strobe combinations.
        do_reset();
        pixel_ready = 1'b1;
        apply_stimulus(1'b1, 1'b1, 16'hDEAD);
        step();
        check_output("ill_high_protocol", protocol_err, 1'b1);
        check_output("ill_high_valid", pixel_valid, 1'b0);
        check_output("ill_high_entries", out_q.size(), 0);
        do_reset();
        pixel_ready = 1'b1;
        apply_stimulus(1'b0, 1'b0, 16'hBEEF);
        step();
        check_output("ill_low_protocol", protocol_err, 1'b1);
        check_output("ill_low_valid", pixel_valid, 1'b0);
        check_output("ill_low_entries", out_q.size(), 0);
        check_output("ill_low_overflow", overflow, 1'b0);

        // Second ADC rise arriving while the first conversion is still in flight.
        do_reset();
        pixel_ready = 1'b1;
        NRE_1 = 1'b0;
        adc_data = 16'h1234;
        ADC = 1'b1;
        step();
        ADC = 1'b0;
        step();
        ADC = 1'b1;
        step();
        ADC = 1'b0;
        repeat (3) step();
        NRE_1 = 1'b1;
        wait_entries(2, "dbl");
        check_output("dbl_out0", out_q[0], 10'h034);
        check_output("dbl_out1", out_q[1], 10'h112);
        check_output("dbl_protocol", protocol_err, 1'b1);

        // Reset during WAIT with entries queued and protocol_err already set.
        pixel_ready = 1'b0;
        apply_stimulus(1'b0, 1'b1, 16'hAA99);
        check_output("mid_pre_valid", pixel_valid, 1'b1);
        NRE_2 = 1'b0;
        adc_data = 16'hCCBB;
        ADC = 1'b1;
        step();
        ADC = 1'b0;
        rst = 1'b1;
        step();
        check_output("mid_valid", pixel_valid, 1'b0);
        check_output("mid_overflow", overflow, 1'b0);
        check_output("mid_protocol", protocol_err, 1'b0);
        rst = 1'b0;
        out_q.delete();
        pixel_ready = 1'b1;
        repeat (8) step();
        NRE_2 = 1'b1;
        check_output("mid_no_entries", out_q.size(), 0);
        check_output("mid_valid_after", pixel_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
